// File: rtl/dpi_flow_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dpi_flow_sched                                                           |
// | Time-multiplexes one DFA engine across interleaved flows, saving and     |
// | restoring per-flow DFA state. Optional per-flow match counters are       |
// | enabled by defining DPI_MATCH_CNT_EN.                                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dpi_flow_sched #(
   parameter int NUM_FLOWS = 4,
   parameter int FLOW_W    = 2,
   parameter int STATE_W   = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_vld,
   input  logic [FLOW_W-1:0]  in_flow,
   input  logic [7:0]         in_char,
   output logic               in_rdy,
   input  logic               clr_vld,
   input  logic [FLOW_W-1:0]  clr_flow,
   output logic [7:0]         eng_char,
   output logic               eng_char_vld,
   output logic [STATE_W-1:0] eng_state,
   output logic               eng_state_vld,
   input  logic [STATE_W-1:0] eng_state_out,
   input  logic               eng_accept,
   output logic               match_vld,
   output logic [FLOW_W-1:0]  match_flow,
   output logic               busy,
   input  logic [FLOW_W-1:0]  cnt_sel,
   output logic [15:0]        cnt_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [FLOW_W-1:0]   act_flow_q, act_flow_d;
   logic [STATE_W-1:0]  ctx_q [NUM_FLOWS];
   logic [STATE_W-1:0]  ctx_d [NUM_FLOWS];
   logic                match_vld_q, match_vld_d;
   logic [FLOW_W-1:0]   match_flow_q, match_flow_d;
   logic                w_accept;
   logic                w_save;
   logic                w_clr_act;

   assign w_clr_act = clr_vld && (clr_flow == act_flow_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         act_flow_q   <= '0;
         match_vld_q  <= 1'b0;
         match_flow_q <= '0;
      end else begin
         state_q      <= state_d;
         act_flow_q   <= act_flow_d;
         match_vld_q  <= match_vld_d;
         match_flow_q <= match_flow_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      act_flow_d    = act_flow_q;
      in_rdy        = 1'b0;
      eng_char_vld  = 1'b0;
      eng_char      = '0;
      eng_state_vld = 1'b0;
      eng_state     = '0;
      w_accept      = 1'b0;
      w_save        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_vld) begin
               act_flow_d = in_flow;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            eng_state_vld = 1'b1;
            eng_state     = w_clr_act ? '0 : ctx_q[act_flow_q];
            state_d       = ST_RUN;
         end
         ST_RUN: begin
            // A switch saves the outgoing flow even when a clear targets it;
            // the clear then overrides that save in the context table.
            if (in_vld && (in_flow != act_flow_q)) begin
               w_save     = 1'b1;
               act_flow_d = in_flow;
               state_d    = ST_LOAD;
            end else if (w_clr_act) begin
               state_d = ST_LOAD;
            end else if (in_vld) begin
               w_accept     = 1'b1;
               in_rdy       = 1'b1;
               eng_char_vld = 1'b1;
               eng_char     = in_char;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      match_vld_d  = w_accept && eng_accept;
      match_flow_d = (w_accept && eng_accept) ? act_flow_q : '0;
   end

   always_comb begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
         ctx_d[i] = ctx_q[i];
         if (clr_vld && (clr_flow == FLOW_W'(i)))
            ctx_d[i] = '0;
         else if (w_save && (act_flow_q == FLOW_W'(i)))
            ctx_d[i] = eng_state_out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_FLOWS; i++) ctx_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_FLOWS; i++) ctx_q[i] <= ctx_d[i];
      end
   end

   assign match_vld  = match_vld_q;
   assign match_flow = match_flow_q;
   assign busy       = (state_q != ST_IDLE);

`ifdef DPI_MATCH_CNT_EN
   logic [15:0] cnt_q [NUM_FLOWS];
   logic [15:0] cnt_d [NUM_FLOWS];

   always_comb begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clr_vld && (clr_flow == FLOW_W'(i)))
            cnt_d[i] = '0;
         else if (match_vld_q && (match_flow_q == FLOW_W'(i)) && (cnt_q[i] != 16'hFFFF))
            cnt_d[i] = cnt_q[i] + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_FLOWS; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_FLOWS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign cnt_out = cnt_q[cnt_sel];
`else
   logic w_unused_cnt_sel;
   assign w_unused_cnt_sel = ^cnt_sel;
   assign cnt_out          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dpi_flow_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dpi_flow_sched                                                        |
// | Directed bench with a counting engine stand-in (state+1 per char,        |
// | accept on 'Z'). Define DPI_MATCH_CNT_EN to also exercise counters.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dpi_flow_sched;

`ifdef DPI_MATCH_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_vld;
   logic [1:0]  in_flow;
   logic [7:0]  in_char;
   logic        in_rdy;
   logic        clr_vld;
   logic [1:0]  clr_flow;
   logic [7:0]  eng_char;
   logic        eng_char_vld;
   logic [10:0] eng_state;
   logic        eng_state_vld;
   logic [10:0] eng_state_out;
   logic        eng_accept;
   logic        match_vld;
   logic [1:0]  match_flow;
   logic        busy;
   logic [1:0]  cnt_sel;
   logic [15:0] cnt_out;

   int n_checks = 0;
   int n_fail   = 0;

   dpi_flow_sched #(.NUM_FLOWS(4), .FLOW_W(2), .STATE_W(11)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_vld        (in_vld),
      .in_flow       (in_flow),
      .in_char       (in_char),
      .in_rdy        (in_rdy),
      .clr_vld       (clr_vld),
      .clr_flow      (clr_flow),
      .eng_char      (eng_char),
      .eng_char_vld  (eng_char_vld),
      .eng_state     (eng_state),
      .eng_state_vld (eng_state_vld),
      .eng_state_out (eng_state_out),
      .eng_accept    (eng_accept),
      .match_vld     (match_vld),
      .match_flow    (match_flow),
      .busy          (busy),
      .cnt_sel       (cnt_sel),
      .cnt_out       (cnt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Engine stand-in: load on state_in_vld, advance by one per character.
   logic [10:0] r_eng_st;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)             r_eng_st <= '0;
      else if (eng_state_vld) r_eng_st <= eng_state;
      else if (eng_char_vld)  r_eng_st <= r_eng_st + 11'd1;
   end
   assign eng_state_out = r_eng_st;
   assign eng_accept    = eng_char_vld && (eng_char == 8'h5A);

   task automatic drive(input logic v, input logic [1:0] f, input logic [7:0] c);
      @(negedge clk);
      in_vld = v; in_flow = f; in_char = c;
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_vld = 0; in_flow = 0; in_char = 0; clr_vld = 0; clr_flow = 0; cnt_sel = 0;
      #1;
      n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_in_rdy got=%0h exp=0", in_rdy); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0h exp=0", busy); end
      n_checks++; if ({eng_state_vld, eng_char_vld, eng_state, eng_char} !== '0) begin n_fail++; $display("FAIL rst_eng got=%0h exp=0", {eng_state_vld, eng_char_vld, eng_state, eng_char}); end
      n_checks++; if ({match_vld, match_flow, cnt_out} !== '0) begin n_fail++; $display("FAIL rst_match got=%0h exp=0", {match_vld, match_flow, cnt_out}); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_stream;
      drive(1, 2'd1, "A");
      n_checks++; if (in_rdy !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL str_idle rdy/busy got=%0h%0h exp=00", in_rdy, busy); end
      drive(1, 2'd1, "A");
      n_checks++; if (eng_state_vld !== 1'b1 || eng_state !== 11'd0) begin n_fail++; $display("FAIL str_load got vld=%0h st=%0h exp vld=1 st=0", eng_state_vld, eng_state); end
      n_checks++; if (in_rdy !== 1'b0 || eng_char_vld !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL str_load_ctl got rdy=%0h cv=%0h busy=%0h exp 0 0 1", in_rdy, eng_char_vld, busy); end
      for (int i = 0; i < 3; i++) begin
         drive(1, 2'd1, 8'("A" + i));
         n_checks++; if (in_rdy !== 1'b1 || eng_char_vld !== 1'b1 || eng_state_vld !== 1'b0 || eng_char !== 8'("A" + i))
            begin n_fail++; $display("FAIL str_run%0d got rdy=%0h cv=%0h sv=%0h ch=%0h exp 1 1 0 %0h", i, in_rdy, eng_char_vld, eng_state_vld, eng_char, 8'("A" + i)); end
      end
      drive(0, 2'd1, 8'h00);
      n_checks++; if (in_rdy !== 1'b0 || eng_char_vld !== 1'b0 || busy !== 1'b1 || match_vld !== 1'b0) begin n_fail++; $display("FAIL str_hold got rdy=%0h cv=%0h busy=%0h mv=%0h exp 0 0 1 0", in_rdy, eng_char_vld, busy, match_vld); end
   endtask

   task automatic test_switch;
      drive(1, 2'd0, "a");
      n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL sw_save0 got rdy=%0h exp=0", in_rdy); end
      drive(1, 2'd0, "a");
      n_checks++; if (in_rdy !== 1'b0 || eng_state_vld !== 1'b1 || eng_state !== 11'd0) begin n_fail++; $display("FAIL sw_load0 got rdy=%0h sv=%0h st=%0h exp 0 1 0", in_rdy, eng_state_vld, eng_state); end
      for (int i = 0; i < 3; i++) begin
         drive(1, 2'd0, 8'("a" + i));
         n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL sw_run0_%0d got rdy=%0h exp=1", i, in_rdy); end
      end
      drive(1, 2'd2, "x");
      n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL sw_save2 got rdy=%0h exp=0", in_rdy); end
      drive(1, 2'd2, "x");
      n_checks++; if (in_rdy !== 1'b0 || eng_state !== 11'd0 || eng_state_vld !== 1'b1) begin n_fail++; $display("FAIL sw_load2 got rdy=%0h st=%0h sv=%0h exp 0 0 1", in_rdy, eng_state, eng_state_vld); end
      drive(1, 2'd2, "x");
      n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL sw_run2 got rdy=%0h exp=1", in_rdy); end
      drive(1, 2'd0, "d");
      n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL sw_back_save got rdy=%0h exp=0", in_rdy); end
      drive(1, 2'd0, "d");
      n_checks++; if (eng_state_vld !== 1'b1 || eng_state !== 11'd3 || eng_char_vld !== 1'b0) begin n_fail++; $display("FAIL sw_resume0 got sv=%0h st=%0h cv=%0h exp 1 3 0", eng_state_vld, eng_state, eng_char_vld); end
      drive(1, 2'd0, "d");
      n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL sw_run0b got rdy=%0h exp=1", in_rdy); end
      drive(1, 2'd1, "e");
      drive(1, 2'd1, "e");
      n_checks++; if (eng_state_vld !== 1'b1 || eng_state !== 11'd3) begin n_fail++; $display("FAIL sw_resume1 got sv=%0h st=%0h exp 1 3", eng_state_vld, eng_state); end
      drive(0, 2'd1, 8'h00);
   endtask

   task automatic test_match;
      cnt_sel = 2'd2;
      drive(1, 2'd2, "Z");
      n_checks++; if (match_vld !== 1'b0) begin n_fail++; $display("FAIL mt_pre got mv=%0h exp=0", match_vld); end
      drive(1, 2'd2, "Z");
      n_checks++; if (eng_state !== 11'd1 || match_vld !== 1'b0) begin n_fail++; $display("FAIL mt_load got st=%0h mv=%0h exp 1 0", eng_state, match_vld); end
      drive(1, 2'd2, "Z");
      n_checks++; if (in_rdy !== 1'b1 || eng_accept !== 1'b1 || match_vld !== 1'b0) begin n_fail++; $display("FAIL mt_acc got rdy=%0h acc=%0h mv=%0h exp 1 1 0", in_rdy, eng_accept, match_vld); end
      drive(0, 2'd2, 8'h00);
      n_checks++; if (match_vld !== 1'b1 || match_flow !== 2'd2) begin n_fail++; $display("FAIL mt_pulse got mv=%0h mf=%0h exp 1 2", match_vld, match_flow); end
      drive(0, 2'd2, 8'h00);
      n_checks++; if (match_vld !== 1'b0) begin n_fail++; $display("FAIL mt_once got mv=%0h exp=0", match_vld); end
      n_checks++; if (cnt_out !== (CNT_EN ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL mt_cnt got=%0d exp=%0d", cnt_out, CNT_EN ? 1 : 0); end
   endtask

   task automatic test_clear;
      cnt_sel = 2'd1;
      drive(1, 2'd1, "Z");
      drive(1, 2'd1, "Z");
      n_checks++; if (eng_state !== 11'd3) begin n_fail++; $display("FAIL cl_load1 got st=%0h exp 3", eng_state); end
      drive(1, 2'd1, "Z");
      n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL cl_run1 got rdy=%0h exp=1", in_rdy); end
      @(negedge clk);
      in_vld = 1; in_flow = 2'd1; in_char = "q"; clr_vld = 1; clr_flow = 2'd1;
      #1;
      n_checks++; if (in_rdy !== 1'b0 || eng_char_vld !== 1'b0) begin n_fail++; $display("FAIL cl_hit got rdy=%0h cv=%0h exp 0 0", in_rdy, eng_char_vld); end
      n_checks++; if (match_vld !== 1'b1 || match_flow !== 2'd1) begin n_fail++; $display("FAIL cl_match got mv=%0h mf=%0h exp 1 1", match_vld, match_flow); end
      @(negedge clk);
      clr_vld = 0;
      #1;
      n_checks++; if (in_rdy !== 1'b0 || eng_state_vld !== 1'b1 || eng_state !== 11'd0) begin n_fail++; $display("FAIL cl_reload got rdy=%0h sv=%0h st=%0h exp 0 1 0", in_rdy, eng_state_vld, eng_state); end
      n_checks++; if (cnt_out !== 16'd0) begin n_fail++; $display("FAIL cl_cnt got=%0d exp=0", cnt_out); end
      drive(1, 2'd1, "q");
      n_checks++; if (in_rdy !== 1'b1 || eng_char !== 8'h71) begin n_fail++; $display("FAIL cl_resume got rdy=%0h ch=%0h exp 1 71", in_rdy, eng_char); end
      drive(1, 2'd0, "r");
      @(negedge clk);
      clr_vld = 1; clr_flow = 2'd0;
      #1;
      n_checks++; if (eng_state_vld !== 1'b1 || eng_state !== 11'd0) begin n_fail++; $display("FAIL cl_load_clr got sv=%0h st=%0h exp 1 0", eng_state_vld, eng_state); end
      @(negedge clk);
      clr_vld = 0;
      #1;
      n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL cl_run0 got rdy=%0h exp=1", in_rdy); end
      drive(0, 2'd0, 8'h00);
   endtask

   task automatic test_reset_mid;
      drive(1, 2'd2, "m");
      drive(1, 2'd2, "m");
      n_checks++; if (eng_state_vld !== 1'b1 || eng_state !== 11'd2) begin n_fail++; $display("FAIL rm_load got sv=%0h st=%0h exp 1 2", eng_state_vld, eng_state); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({in_rdy, busy, eng_state_vld, eng_char_vld, eng_state, eng_char, match_vld, match_flow} !== '0)
         begin n_fail++; $display("FAIL rm_outs got=%0h exp=0", {in_rdy, busy, eng_state_vld, eng_char_vld, eng_state, eng_char, match_vld, match_flow}); end
      @(negedge clk);
      in_vld = 0; rst_n = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_idle got busy=%0h exp=0", busy); end
      drive(1, 2'd2, "m");
      n_checks++; if (in_rdy !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_idle2 got rdy=%0h busy=%0h exp 0 0", in_rdy, busy); end
      drive(1, 2'd2, "m");
      n_checks++; if (eng_state !== 11'd0 || eng_state_vld !== 1'b1) begin n_fail++; $display("FAIL rm_ctx2 got st=%0h sv=%0h exp 0 1", eng_state, eng_state_vld); end
      drive(1, 2'd2, "m");
      drive(1, 2'd0, "n");
      drive(1, 2'd0, "n");
      n_checks++; if (eng_state !== 11'd0 || eng_state_vld !== 1'b1) begin n_fail++; $display("FAIL rm_ctx0 got st=%0h sv=%0h exp 0 1", eng_state, eng_state_vld); end
      drive(0, 2'd0, 8'h00);
   endtask

   task automatic test_saturate;
      cnt_sel = 2'd3;
      drive(1, 2'd3, "Z");
      repeat (65540) @(negedge clk);
      #1;
      n_checks++; if (cnt_out !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt got=%0d exp=65535", cnt_out); end
      drive(0, 2'd3, 8'h00);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_switch();
      test_match();
      test_clear();
      test_reset_mid();
      if (CNT_EN) test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
